updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
Parametrised up/down counter with enable, synchronous parallel load and a programmable range [lo, hi], step size and wrap/saturate mode. Generalises the team's fixed 4-bit wrap-at-0/15 counter. It is used as the generic counting element in lab datapaths: timers, address generators and display scanners. It also reports a terminal-count pulse, a sticky overflow flag and a configuration error.

Parameters:
WIDTH, 4, counter and data width in bits (>= 2)
RESET_VAL, 0, value of out after reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = counter may change this cycle; 0 = hold everything except clr_ovf
load  input  1  with en=1: out <= data (takes priority over counting)
dir  input  1  1 = count up, 0 = count down
data  input  WIDTH  parallel load value
lo  input  WIDTH  lower bound, inclusive
hi  input  WIDTH  upper bound, inclusive
step  input  WIDTH  increment/decrement magnitude, unsigned
sat  input  1  1 = saturate at bound, 0 = wrap to opposite bound
clr_ovf  input  1  synchronous clear of ovf
out  output  WIDTH  registered count
tc  output  1  registered, one-cycle pulse on a boundary event
ovf  output  1  registered, sticky, set on any boundary event
cfg_err  output  1  combinational, 1 when lo > hi

Behaviour:
- Reset (rst_n=0, asynchronous): out=RESET_VAL, tc=0, ovf=0. Release is sampled at the next clk edge. Reset mid-count aborts immediately.
- All state updates occur on posedge clk. Per-cycle priority: en=0 -> hold out, tc<=0; en=1 & load=1 -> out<=data, tc<=0.
- The load path does not range-check. Out-of-range data is loaded verbatim.
- Counting applies only when en=1, load=0, cfg_err=0 and step!=0. Otherwise out holds and tc<=0.
- All comparisons use WIDTH+1 bits; no silent modulo-2^WIDTH wrap is permitted.
- Up (dir=1), let s = out + step:
  - If s <= hi: out<=s, no boundary event.
  - If s > hi: boundary event. out<=hi when sat=1, or out<=lo when sat=0.
- Down (dir=0):
  - If out >= lo + step: out<=out-step, no boundary event.
  - Otherwise: boundary event. out<=lo when sat=1, or out<=hi when sat=0.
- A saturated counter that keeps counting into its bound raises a boundary event every enabled cycle, so tc stays high while pinned.
- Boundary event effects, visible in the same cycle as the new out value: tc<=1 for that cycle only, and ovf<=1.
- clr_ovf=1 clears ovf regardless of en. If clr_ovf and a boundary event occur in the same cycle, set wins (ovf=1).
- An out value above hi, e.g. after an out-of-range load, counting up triggers a boundary event on the next count.
- An out value below lo counting down likewise triggers a boundary event on the next count.
- cfg_err (lo > hi) freezes counting; load still works. lo == hi is legal: every count is a boundary event and out<=lo.
- Latency: one clock from qualified input to out/tc/ovf. There is no combinational path from inputs to out, tc or ovf.
- Default configuration (WIDTH=4, lo=0, hi=15, step=1, sat=0) reproduces the legacy 4-bit counter exactly. The one exception is reset, which is now asynchronous.

Test Plan:
- Legacy mode: WIDTH=4, lo=0, hi=15, step=1, sat=0, en=1, dir=1, from out=14 -> out 15, then 0 with tc=1 and ovf=1. With dir=0 from 0 -> out 15 with tc=1.
- Range/step: lo=3, hi=12, step=4, sat=0, load 3, count up -> 7, 11, 3 (tc=1 on the 3), 7. Then dir=0 from 7 -> 3, then 12 (tc=1).
- Saturate: lo=2, hi=10, step=3, sat=1, load 8, count up -> 10 (tc=1), 10 (tc=1), with ovf=1 throughout. Then clr_ovf=1 with en=0 -> ovf=0 and out stays 10.
- Priority and hold: en=0 with load=1, data=5 -> out unchanged, tc=0. Then en=1, load=1, dir=1 at a bound -> out=5, tc=0, ovf unchanged.
- Corner cases:
  - clr_ovf coincident with a boundary event -> ovf=1.
  - step=0 -> out holds, tc=0.
  - lo=9, hi=4 -> cfg_err=1, counting frozen, load of 6 still takes effect.
  - Out-of-range load of 14 with hi=12, count up -> boundary event.
- Async reset: assert rst_n=0 mid-count between clock edges -> out=RESET_VAL, tc=0 and ovf=0 immediately. After release, counting resumes from RESET_VAL on the first enabled edge.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable range, step and wrap/saturate.
// Reports a terminal-count pulse, a sticky overflow flag and a config error.
module updown_counter_param #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             dir,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             cfg_err
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_min;
  logic             up_evt;
  logic             dn_evt;
  logic             cnt_ok;
  logic             evt;

  assign cfg_err = lo > hi;

  // Bounds are checked one bit wider so a sum past 2^WIDTH is never lost.
  assign up_sum = {1'b0, out_q} + {1'b0, step};
  assign dn_min = {1'b0, lo} + {1'b0, step};
  assign up_evt = up_sum > {1'b0, hi};
  assign dn_evt = {1'b0, out_q} < dn_min;

  assign cnt_ok = en & ~load & ~cfg_err & (step != '0);

  always_comb begin
    out_d = out_q;
    evt   = 1'b0;
    if (en && load) begin
      out_d = data;
    end else if (cnt_ok) begin
      if (dir) begin
        if (up_evt) begin
          evt   = 1'b1;
          out_d = sat ? hi : lo;
        end else begin
          out_d = up_sum[WIDTH-1:0];
        end
      end else begin
        if (dn_evt) begin
          evt   = 1'b1;
          out_d = sat ? lo : hi;
        end else begin
          out_d = out_q - step;
        end
      end
    end
    tc_d  = evt;
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (evt)     ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RESET_VAL;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param (WIDTH=4, RESET_VAL=5).
// Expected {out,tc,ovf} are queued per driven cycle and compared per task.
module tb_updown_counter_param;

  typedef struct packed {
    logic [3:0] o;
    logic       t;
    logic       v;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, load, dir, sat, clr_ovf;
  logic [3:0] data, lo, hi, step;
  logic [3:0] out;
  logic       tc, ovf, cfg_err;

  int n_run  = 0;
  int n_fail = 0;

  res_t exp_q[$];
  res_t act_q[$];

  updown_counter_param #(.WIDTH(4), .RESET_VAL(4'd5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .dir(dir),
    .data(data), .lo(lo), .hi(hi), .step(step), .sat(sat),
    .clr_ovf(clr_ovf), .out(out), .tc(tc), .ovf(ovf),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic cfg(input logic [3:0] l, input logic [3:0] h,
                     input logic [3:0] s, input logic st);
    lo = l; hi = h; step = s; sat = st;
  endtask

  task automatic drive(input logic e, input logic ld, input logic d,
                       input logic [3:0] dt, input logic c,
                       input logic [3:0] eo, input logic et,
                       input logic ev);
    res_t x;
    @(negedge clk);
    en = e; load = ld; dir = d; data = dt; clr_ovf = c;
    x.o = eo; x.t = et; x.v = ev;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x.o = out; x.t = tc; x.v = ovf;
    act_q.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 0; load = 0; dir = 1; data = 0; clr_ovf = 0;
    cfg(4'd0, 4'd15, 4'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if ({out, tc, ovf} !== {4'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got out=%0d tc=%b ovf=%b, need 5 0 0",
               out, tc, ovf);
    end
    n_run++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cfg_err: got %b, need 0", cfg_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_legacy();
    res_t x, y;
    cfg(4'd0, 4'd15, 4'd1, 1'b0);
    drive(1, 1, 1, 4'd14, 0, 4'd14, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd15, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd0, 1, 1);
    drive(1, 0, 1, 4'd0, 0, 4'd1, 0, 1);
    drive(1, 1, 0, 4'd0, 0, 4'd0, 0, 1);
    drive(1, 0, 0, 4'd0, 0, 4'd15, 1, 1);
    drive(0, 0, 0, 4'd0, 1, 4'd15, 0, 0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_run++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL legacy: no output, need %h", x);
      end else begin
        y = act_q.pop_front();
        if (y !== x) begin
          n_fail++;
          $display("FAIL legacy: got out=%0d tc=%b ovf=%b, need %0d %b %b",
                   y.o, y.t, y.v, x.o, x.t, x.v);
        end
      end
    end
  endtask

  task automatic test_range();
    res_t x, y;
    cfg(4'd3, 4'd12, 4'd4, 1'b0);
    drive(1, 1, 1, 4'd3, 0, 4'd3, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd7, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd11, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd3, 1, 1);
    drive(1, 0, 1, 4'd0, 0, 4'd7, 0, 1);
    drive(1, 0, 0, 4'd0, 0, 4'd3, 0, 1);
    drive(1, 0, 0, 4'd0, 0, 4'd12, 1, 1);
    drive(0, 0, 0, 4'd0, 1, 4'd12, 0, 0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_run++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL range: no output, need %h", x);
      end else begin
        y = act_q.pop_front();
        if (y !== x) begin
          n_fail++;
          $display("FAIL range: got out=%0d tc=%b ovf=%b, need %0d %b %b",
                   y.o, y.t, y.v, x.o, x.t, x.v);
        end
      end
    end
  endtask

  task automatic test_saturate();
    res_t x, y;
    cfg(4'd2, 4'd10, 4'd3, 1'b1);
    drive(1, 1, 1, 4'd8, 0, 4'd8, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd10, 1, 1);
    drive(1, 0, 1, 4'd0, 0, 4'd10, 1, 1);
    drive(0, 0, 1, 4'd0, 1, 4'd10, 0, 0);
    drive(1, 1, 0, 4'd3, 0, 4'd3, 0, 0);
    drive(1, 0, 0, 4'd0, 0, 4'd2, 1, 1);
    drive(1, 0, 0, 4'd0, 0, 4'd2, 1, 1);
    drive(0, 0, 0, 4'd0, 1, 4'd2, 0, 0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_run++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL saturate: no output, need %h", x);
      end else begin
        y = act_q.pop_front();
        if (y !== x) begin
          n_fail++;
          $display("FAIL saturate: got out=%0d tc=%b ovf=%b, need %0d %b %b",
                   y.o, y.t, y.v, x.o, x.t, x.v);
        end
      end
    end
  endtask

  task automatic test_priority();
    res_t x, y;
    cfg(4'd2, 4'd10, 4'd3, 1'b1);
    drive(1, 1, 1, 4'd10, 0, 4'd10, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd10, 1, 1);
    drive(0, 1, 1, 4'd5, 0, 4'd10, 0, 1);
    drive(1, 1, 1, 4'd5, 0, 4'd5, 0, 1);
    drive(0, 0, 1, 4'd0, 1, 4'd5, 0, 0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_run++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL priority: no output, need %h", x);
      end else begin
        y = act_q.pop_front();
        if (y !== x) begin
          n_fail++;
          $display("FAIL priority: got out=%0d tc=%b ovf=%b, need %0d %b %b",
                   y.o, y.t, y.v, x.o, x.t, x.v);
        end
      end
    end
  endtask

  task automatic test_corners();
    res_t x, y;
    cfg(4'd0, 4'd15, 4'd1, 1'b0);
    drive(1, 1, 1, 4'd15, 0, 4'd15, 0, 0);
    drive(1, 0, 1, 4'd0, 1, 4'd0, 1, 1);
    drive(1, 0, 1, 4'd0, 1, 4'd1, 0, 0);
    cfg(4'd0, 4'd15, 4'd0, 1'b0);
    drive(1, 0, 1, 4'd0, 0, 4'd1, 0, 0);
    drive(1, 0, 0, 4'd0, 0, 4'd1, 0, 0);
    cfg(4'd9, 4'd4, 4'd1, 1'b0);
    #1;
    n_run++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_err_set: got %b, need 1", cfg_err);
    end
    drive(1, 0, 1, 4'd0, 0, 4'd1, 0, 0);
    drive(1, 1, 1, 4'd6, 0, 4'd6, 0, 0);
    drive(1, 0, 0, 4'd0, 0, 4'd6, 0, 0);
    cfg(4'd3, 4'd12, 4'd4, 1'b0);
    #1;
    n_run++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_clear: got %b, need 0", cfg_err);
    end
    drive(1, 1, 1, 4'd14, 0, 4'd14, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd3, 1, 1);
    drive(1, 1, 0, 4'd1, 0, 4'd1, 0, 1);
    drive(1, 0, 0, 4'd0, 0, 4'd12, 1, 1);
    cfg(4'd7, 4'd7, 4'd1, 1'b0);
    drive(1, 0, 1, 4'd0, 0, 4'd7, 1, 1);
    drive(1, 0, 0, 4'd0, 0, 4'd7, 1, 1);
    cfg(4'd0, 4'd15, 4'd8, 1'b0);
    drive(1, 1, 1, 4'd12, 0, 4'd12, 0, 1);
    drive(1, 0, 1, 4'd0, 0, 4'd0, 1, 1);
    drive(0, 0, 1, 4'd0, 1, 4'd0, 0, 0);
    cfg(4'd2, 4'd15, 4'd15, 1'b1);
    drive(1, 1, 0, 4'd15, 0, 4'd15, 0, 0);
    drive(1, 0, 0, 4'd0, 0, 4'd2, 1, 1);
    drive(0, 0, 0, 4'd0, 1, 4'd2, 0, 0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_run++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL corners: no output, need %h", x);
      end else begin
        y = act_q.pop_front();
        if (y !== x) begin
          n_fail++;
          $display("FAIL corners: got out=%0d tc=%b ovf=%b, need %0d %b %b",
                   y.o, y.t, y.v, x.o, x.t, x.v);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    res_t x, y;
    cfg(4'd0, 4'd15, 4'd1, 1'b0);
    drive(1, 1, 1, 4'd14, 0, 4'd14, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd15, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd0, 1, 1);
    #2;
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({out, tc, ovf} !== {4'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got out=%0d tc=%b ovf=%b, need 5 0 0",
               out, tc, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 1, 4'd0, 0, 4'd6, 0, 0);
    drive(1, 0, 1, 4'd0, 0, 4'd7, 0, 0);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_run++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL async_resume: no output, need %h", x);
      end else begin
        y = act_q.pop_front();
        if (y !== x) begin
          n_fail++;
          $display("FAIL async_resume: got out=%0d tc=%b ovf=%b, need %0d %b %b",
                   y.o, y.t, y.v, x.o, x.t, x.v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_range();
    test_saturate();
    test_priority();
    test_corners();
    test_async_reset();
    n_run++;
    if (act_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d unmatched outputs, need 0",
               act_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
